// File: rtl/fetch_unit.sv
// fetch_unit: PC, imem valid/ready requests and an in-order instruction buffer feeding decode.
// Define FETCH_PERF_EN to add perf_fetched / perf_squashed counters.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 4
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic [31:0] pc_plus_8,
   output logic [3:0]  condition,
   output logic [1:0]  operation_code,
   output logic [5:0]  function_id,
   output logic [3:0]  destination_register
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_squashed
`endif
);
   localparam int AW = $clog2(DEPTH);
   logic [31:0]   pc, resp_pc, redirect_aligned;
   logic [31:0]   buf_data [DEPTH];
   logic [31:0]   buf_pc [DEPTH];
   logic [AW-1:0] head, tail;
   logic [AW:0]   count, outstanding, discard;
   logic [AW+1:0] occupancy;
   logic          accept, pop, push, drop;

   assign redirect_aligned = redirect_pc & ~32'd3;
   // outstanding counts every in-flight request, including ones already marked for discard
   assign occupancy      = (AW+2)'(count) + (AW+2)'(outstanding);
   assign imem_req_valid = !reset && !redirect_valid && occupancy < (AW+2)'(DEPTH);
   assign imem_req_addr  = pc;
   assign accept         = imem_req_valid & imem_req_ready;
   assign instr_valid    = !reset && count != '0;
   assign pop            = instr_valid & instr_ready;
   assign drop           = imem_resp_valid && (redirect_valid || discard != '0);
   assign push           = imem_resp_valid && !drop;

   always_ff @(posedge clk) begin
      if (reset) begin
         pc          <= RESET_PC;
         resp_pc     <= RESET_PC;
         head        <= '0;
         tail        <= '0;
         count       <= '0;
         outstanding <= '0;
         discard     <= '0;
      end else begin
         outstanding <= outstanding + (AW+1)'(accept) - (AW+1)'(imem_resp_valid);
         if (redirect_valid) begin
            pc      <= redirect_aligned;
            resp_pc <= redirect_aligned;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            discard <= outstanding - (AW+1)'(imem_resp_valid);
         end else begin
            if (accept) pc <= pc + 32'd4;
            if (imem_resp_valid && discard != '0) discard <= discard - (AW+1)'(1);
            if (push) begin
               tail    <= tail + AW'(1);
               resp_pc <= resp_pc + 32'd4;
            end
            if (pop) head <= head + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push && !reset) begin
         buf_data[tail] <= imem_resp_data;
         buf_pc[tail]   <= resp_pc;
      end
   end

   assign instr                = instr_valid ? buf_data[head] : '0;
   assign instr_pc             = instr_valid ? buf_pc[head] : '0;
   assign pc_plus_8            = instr_valid ? buf_pc[head] + 32'd8 : '0;
   assign condition            = instr[31:28];
   assign operation_code       = instr[27:26];
   assign function_id          = instr[25:20];
   assign destination_register = instr[15:12];

`ifdef FETCH_PERF_EN
   logic [32:0] fetched_sum, squashed_sum;
   assign fetched_sum  = {1'b0, perf_fetched} + 33'(pop);
   assign squashed_sum = {1'b0, perf_squashed} + 33'(drop)
                       + (redirect_valid ? 33'(count - (AW+1)'(pop)) : 33'd0);

   always_ff @(posedge clk) begin
      if (reset) begin
         perf_fetched  <= '0;
         perf_squashed <= '0;
      end else begin
         perf_fetched  <= fetched_sum[32] ? '1 : fetched_sum[31:0];
         perf_squashed <= squashed_sum[32] ? '1 : squashed_sum[31:0];
      end
   end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: random and directed stimulus against an epoch-tagged memory and stream model.
module tb_fetch_unit;
   localparam int DEPTH = 4;
   logic clk, reset, imem_req_ready, imem_resp_valid, redirect_valid, instr_ready;
   logic [31:0] imem_resp_data, redirect_pc;
   logic imem_req_valid, instr_valid, imem_req_valid_w, instr_valid_w;
   logic [31:0] imem_req_addr, instr, instr_pc, pc_plus_8;
   logic [31:0] imem_req_addr_w, instr_w, instr_pc_w, pc_plus_8_w;
   logic [3:0] condition, destination_register, condition_w, destination_register_w;
   logic [1:0] operation_code, operation_code_w;
   logic [5:0] function_id, function_id_w;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched, perf_squashed, perf_fetched_w, perf_squashed_w;
`endif

   fetch_unit #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc), .pc_plus_8(pc_plus_8),
      .condition(condition), .operation_code(operation_code), .function_id(function_id),
      .destination_register(destination_register)
`ifdef FETCH_PERF_EN
      , .perf_fetched(perf_fetched), .perf_squashed(perf_squashed)
`endif
   );

   // Wrap-around instance: shares every input, so its control runs in lockstep with dut
   fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) dut_w (
      .clk(clk), .reset(reset), .imem_req_valid(imem_req_valid_w), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr_w), .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .instr_valid(instr_valid_w),
      .instr_ready(instr_ready), .instr(instr_w), .instr_pc(instr_pc_w), .pc_plus_8(pc_plus_8_w),
      .condition(condition_w), .operation_code(operation_code_w), .function_id(function_id_w),
      .destination_register(destination_register_w)
`ifdef FETCH_PERF_EN
      , .perf_fetched(perf_fetched_w), .perf_squashed(perf_squashed_w)
`endif
   );

   typedef struct {
      logic [31:0] addr;
      int          due;
      int          ep;
   } req_t;

   req_t        pend[$];
   int          total, bad, cyc, rel, lat, epoch, avail, last_due;
   logic [31:0] exp_pc, exp_req, m_fetched, m_squashed;
   logic        nxt_reset, nxt_rdy, nxt_ird, nxt_rd, acc;
   logic [31:0] nxt_rd_pc;

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] word(input logic [31:0] a);
      return a == 32'h10 ? 32'hE281_1005 : (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   // One clock: apply inputs at negedge, sample 1ns later, then advance the model past the posedge
   task automatic cycle();
      req_t r;
      logic got_resp, pop;
      logic [31:0] w;
      int d;
      @(negedge clk);
      reset = nxt_reset; imem_req_ready = nxt_rdy; instr_ready = nxt_ird;
      redirect_valid = nxt_rd; redirect_pc = nxt_rd_pc;
      got_resp = 0; imem_resp_valid = 0; imem_resp_data = '0;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
         r = pend.pop_front();
         got_resp = 1; imem_resp_valid = 1; imem_resp_data = word(r.addr);
      end
      #1;
      acc = 0;
      if (reset) begin
         chk("rst_req_valid", imem_req_valid, 0);
         chk("rst_instr_valid", instr_valid, 0);
         chk("rst_instr_zero", instr | instr_pc | pc_plus_8, 0);
         avail = 0; epoch++; exp_pc = 0; exp_req = 0; m_fetched = 0; m_squashed = 0; rel = 0;
      end else begin
         rel++;
`ifdef FETCH_PERF_EN
         chk("perf_fetched", perf_fetched, m_fetched);
         chk("perf_squashed", perf_squashed, m_squashed);
`endif
         chk("instr_valid", instr_valid, avail > 0);
         chk("req_gate", imem_req_valid, !redirect_valid && (avail + pend.size() + 32'(got_resp) < DEPTH));
         if (instr_valid) begin
            w = word(exp_pc);
            chk("instr_pc", instr_pc, exp_pc);
            chk("instr", instr, w);
            chk("pc_plus_8", pc_plus_8, exp_pc + 8);
            chk("fields", {condition, operation_code, function_id, destination_register}, {w[31:20], w[15:12]});
            if (exp_pc == 32'h10) begin
               chk("add_cond", condition, 4'hE);
               chk("add_opc", operation_code, 2'b00);
               chk("add_funct", function_id, 6'b101000);
               chk("add_rd", destination_register, 4'h1);
            end
         end else begin
            chk("idle_zero", instr | instr_pc | pc_plus_8 | {condition, operation_code, function_id, destination_register}, 0);
         end
         acc = imem_req_valid & imem_req_ready;
         if (acc) begin
            chk("req_addr", imem_req_addr, exp_req);
            d = cyc + lat;
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            pend.push_back('{imem_req_addr, d, epoch});
            exp_req += 4;
         end
         pop = instr_valid & instr_ready;
         if (pop) begin
            exp_pc += 4; avail--; m_fetched++;
         end
         if (got_resp) begin
            if (r.ep == epoch && !redirect_valid) avail++;
            else m_squashed++;
         end
         if (redirect_valid) begin
            m_squashed += 32'(avail); avail = 0; epoch++;
            exp_pc = redirect_pc & ~32'd3; exp_req = exp_pc;
         end
         chk("no_overflow", avail <= DEPTH, 1);
      end
      cyc++;
   endtask

   task automatic do_reset();
      int n = 0;
      nxt_rdy = 0; nxt_rd = 0;
      while (pend.size() > 0 && n < 30) begin
         cycle();
         n++;
      end
      chk("drain", pend.size(), 0);
      nxt_reset = 1;
      cycle();
      cycle();
      nxt_reset = 0;
   endtask

   initial begin
      int n;
      logic [31:0] wrap_addr[3];
      wrap_addr = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
      total = 0; bad = 0; cyc = 0; rel = 0; lat = 1; epoch = 0; avail = 0; last_due = -1;
      exp_pc = 0; exp_req = 0; m_fetched = 0; m_squashed = 0;
      nxt_reset = 1; nxt_rdy = 0; nxt_ird = 0; nxt_rd = 0; nxt_rd_pc = 0;
      reset = 1; imem_req_ready = 0; instr_ready = 0; redirect_valid = 0; redirect_pc = 0;
      imem_resp_valid = 0; imem_resp_data = 0;
      do_reset();

      // Streaming: ready memory, 1-cycle latency, decode always ready
      nxt_rdy = 1; nxt_ird = 1; lat = 1;
      for (int i = 0; i < 10; i++) begin
         cycle();
         chk("a_req_valid", imem_req_valid, 1);
         chk("a_valid", instr_valid, rel >= 3);
         if (rel <= 3) begin
            chk("a_addr", imem_req_addr, 32'((rel - 1) * 4));
            chk("w_addr", imem_req_addr_w, wrap_addr[rel-1]);
         end
         if (rel >= 3 && rel <= 5) chk("w_pc", instr_pc_w, wrap_addr[rel-3]);
         if (rel == 3) begin
            chk("a_first_pc", instr_pc, 0);
            chk("a_first_pc8", pc_plus_8, 8);
         end
`ifdef FETCH_PERF_EN
         if (rel == 6) begin
            chk("w_perf_fetched", perf_fetched_w, 3);
            chk("w_perf_squashed", perf_squashed_w, 0);
         end
`endif
      end

      // Backpressure: decode stalls for 10 cycles
      do_reset();
      nxt_rdy = 1; nxt_ird = 0; lat = 1; n = 0;
      for (int i = 0; i < 10; i++) begin
         cycle();
         n += int'(acc);
      end
      chk("b_accepts", n, 4);
      chk("b_req_low", imem_req_valid, 0);
      chk("b_count", avail, 4);
      nxt_ird = 1;
      for (int k = 0; k < 4; k++) begin
         cycle();
         chk("b_valid", instr_valid, 1);
         chk("b_pc", instr_pc, 32'(k * 4));
      end

      // Redirect with three requests in flight at 3-cycle latency
      lat = 3; n = 0;
      do begin
         cycle();
         n++;
      end while (pend.size() != 3 && n < 40);
      chk("c_outstanding", pend.size(), 3);
      nxt_rd = 1; nxt_rd_pc = 32'h0000_0102;
      cycle();
      chk("c_rd_req_low", imem_req_valid, 0);
      nxt_rd = 0;
      cycle();
      chk("c_flush", instr_valid, 0);
      chk("c_req_valid", imem_req_valid, 1);
      chk("c_req_addr", imem_req_addr, 32'h100);
      n = 0;
      while (!instr_valid && n < 20) begin
         cycle();
         n++;
      end
      chk("c_arrived", instr_valid, 1);
      chk("c_first_pc", instr_pc, 32'h100);

      // Redirect on a cycle with a response and a consume, then redirect again next cycle
      lat = 2; n = 0;
      while (!(pend.size() > 0 && pend[0].due <= cyc && avail > 0) && n < 60) begin
         cycle();
         n++;
      end
      chk("d_setup", n < 60, 1);
      nxt_rd = 1; nxt_rd_pc = 32'h180;
      cycle();
      chk("d_consume", instr_valid & instr_ready, 1);
      nxt_rd_pc = 32'h200;
      cycle();
      nxt_rd = 0; n = 0;
      do begin
         cycle();
         n++;
      end while (!instr_valid && n < 20);
      chk("d_arrived", instr_valid, 1);
      chk("d_first_pc", instr_pc, 32'h200);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         nxt_rdy = ($urandom % 4) != 0;
         nxt_ird = ($urandom % 3) != 0;
         nxt_rd = ($urandom % 20) == 0;
         nxt_rd_pc = $urandom;
         lat = 1 + int'($urandom % 4);
         cycle();
      end
      nxt_rd = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
